// File: rtl/sha256_digest_serializer_pkg.sv
// Shared types and constants for the SHA-256 digest output stage.
package sha256_out_pkg;

    localparam int unsigned DIGEST_W     = 256;
    localparam int unsigned DIGEST_BYTES = 32;
    localparam int unsigned LZ_W         = 9;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/sha256_digest_serializer_if.sv
// Valid/ready byte stream from the digest serializer toward the board output path.
interface sha256_digest_serializer_if;
    logic [7:0] byte_o;
    logic       valid_o;
    logic       ready_i;

    modport master (output byte_o, output valid_o, input ready_i);
    modport slave  (input byte_o, input valid_o, output ready_i);
endinterface

// File: rtl/sha256_digest_serializer_lzc256.sv
// Combinational leading-zero counter over a 256-bit word; all-zero input yields 256.
module lzc256
    import sha256_out_pkg::*;
(
    input  logic [255:0]    data_i,
    output logic [LZ_W-1:0] count_o
);

    logic found;

    always_comb begin
        count_o = LZ_W'(256);
        found   = 1'b0;
        for (int i = 255; i >= 0; i--) begin
            if (!found && data_i[i]) begin
                count_o = LZ_W'(255 - i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha256_digest_serializer.sv
// Captures the SHA-256 digest on the rising edge of the core's ready level and streams it
// out as 32 bytes over a valid/ready interface; also records the digest's leading-zero count.
module sha256_digest_serializer
    import sha256_out_pkg::*;
#(
    parameter int unsigned DIGEST_W  = 256,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy_i,
    input  logic [DIGEST_W-1:0]   hash_i,
    sha256_digest_serializer_if.master out_if,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [LZ_W-1:0]       lz_count_o,
    output logic                  overrun_o
);

    state_e              state_q;
    logic [DIGEST_W-1:0] shift_q;
    logic [4:0]          cnt_q;
    logic                rdy_prev_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic [LZ_W-1:0]     lz_q;
    logic                overrun_q;

    logic                rise;
    logic                xfer;
    logic [LZ_W-1:0]     lz_new;
    logic [DIGEST_W-1:0] shift_next;

    lzc256 u_lzc (
        .data_i  (hash_i[255:0]),
        .count_o (lz_new)
    );

    assign rise = rdy_i & ~rdy_prev_q;
    assign xfer = valid_q & out_if.ready_i;

    // Shift toward whichever end feeds byte_o.
    assign shift_next = MSB_FIRST ? {shift_q[DIGEST_W-9:0], 8'h00}
                                  : {8'h00, shift_q[DIGEST_W-1:8]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            rdy_prev_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            lz_q       <= '0;
            overrun_q  <= 1'b0;
        end else begin
            rdy_prev_q <= rdy_i;
            done_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        shift_q <= hash_i;
                        cnt_q   <= '0;
                        lz_q    <= lz_new;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    // A digest arriving mid-stream is dropped; only the flag records it.
                    if (rise) begin
                        overrun_q <= 1'b1;
                    end
                    if (xfer) begin
                        if (cnt_q == 5'(DIGEST_BYTES - 1)) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            shift_q <= shift_next;
                            cnt_q   <= cnt_q + 5'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_if.byte_o  = MSB_FIRST ? shift_q[DIGEST_W-1 -: 8] : shift_q[7:0];
    assign out_if.valid_o = valid_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign lz_count_o     = lz_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Directed bench: MSB-first and LSB-first serializers driven from shared digest stimulus.
module tb_sha256_digest_serializer;
    import sha256_out_pkg::*;

    localparam logic [255:0] ABC   =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] OTHER =
        256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;

    logic         clk;
    logic         rst;
    logic         rdy;
    logic [255:0] hash;
    logic         ready;

    logic         busy0, done0, ovr0;
    logic         busy1, done1, ovr1;
    logic [8:0]   lz0, lz1;

    int n_assert = 0;
    int n_fail   = 0;

    sha256_digest_serializer_if if0 ();
    sha256_digest_serializer_if if1 ();
    assign if0.ready_i = ready;
    assign if1.ready_i = ready;

    sha256_digest_serializer #(.DIGEST_W(256), .MSB_FIRST(1'b1)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .rdy_i      (rdy),
        .hash_i     (hash),
        .out_if     (if0),
        .busy_o     (busy0),
        .done_o     (done0),
        .lz_count_o (lz0),
        .overrun_o  (ovr0)
    );

    sha256_digest_serializer #(.DIGEST_W(256), .MSB_FIRST(1'b0)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .rdy_i      (rdy),
        .hash_i     (hash),
        .out_if     (if1),
        .busy_o     (busy1),
        .done_o     (done1),
        .lz_count_o (lz1),
        .overrun_o  (ovr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise rdy for one cycle with digest h; returns at the negedge after the capture edge.
    task automatic capture(input logic [255:0] h);
        hash = h;
        rdy  = 1'b1;
        @(negedge clk);
        rdy  = 1'b0;
        chk("cap_valid", 256'(if0.valid_o), 256'd1);
        chk("cap_busy", 256'(busy0), 256'd1);
    endtask

    // Collect bytes first..last-1 of h. mode 0: ready always high; mode 1: ready 1,0,0,...
    task automatic stream(input logic [255:0] h, input int mode, input int first,
                          input int last, input bit chk_lsb);
        int         k   = first;
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [7:0] prev = 8'h00;
        logic [7:0] exp_b;
        while (k < last && cyc < 200) begin
            ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            chk("valid", 256'(if0.valid_o), 256'd1);
            if (stalled) chk("stall_hold", 256'(if0.byte_o), 256'(prev));
            if (ready) begin
                exp_b = h[255 - 8*k -: 8];
                chk($sformatf("msb_byte%0d", k), 256'(if0.byte_o), 256'(exp_b));
                if (chk_lsb) begin
                    exp_b = h[8*k +: 8];
                    chk($sformatf("lsb_byte%0d", k), 256'(if1.byte_o), 256'(exp_b));
                end
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prev    = if0.byte_o;
            end
            cyc++;
            @(negedge clk);
        end
        if (k < last) begin
            n_assert++;
            n_fail++;
            $error("FAIL stream_timeout: observed %0d bytes expected %0d", k, last);
        end
        ready = 1'b0;
        if (last == DIGEST_BYTES) begin
            chk("done_pulse", 256'(done0), 256'd1);
            chk("end_valid", 256'(if0.valid_o), 256'd0);
            chk("end_busy", 256'(busy0), 256'd0);
            @(negedge clk);
            chk("done_drop", 256'(done0), 256'd0);
        end
    endtask

    initial begin
        rst   = 1'b0;
        rdy   = 1'b0;
        hash  = '0;
        ready = 1'b0;
        @(negedge clk);
        chk("rst_valid", 256'(if0.valid_o), 256'd0);
        chk("rst_busy", 256'(busy0), 256'd0);
        chk("rst_done", 256'(done0), 256'd0);
        chk("rst_byte", 256'(if0.byte_o), 256'd0);
        chk("rst_lz", 256'(lz0), 256'd0);
        chk("rst_ovr", 256'(ovr0), 256'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_valid", 256'(if0.valid_o), 256'd0);

        // "abc" digest, full rate, both byte orders
        capture(ABC);
        chk("abc_lz", 256'(lz0), 256'd0);
        stream(ABC, 0, 0, DIGEST_BYTES, 1'b1);

        // Same digest with sink stalls
        capture(ABC);
        stream(ABC, 1, 0, DIGEST_BYTES, 1'b0);

        // All-zero digest
        capture(256'h0);
        chk("zero_lz", 256'(lz0), 256'd256);
        chk("zero_lz_lsb", 256'(lz1), 256'd256);
        stream(256'h0, 0, 0, DIGEST_BYTES, 1'b0);

        // 20 leading zero bits
        capture({20'h0, {236{1'b1}}});
        chk("lz20", 256'(lz0), 256'd20);
        stream({20'h0, {236{1'b1}}}, 0, 0, DIGEST_BYTES, 1'b0);
        chk("lz_hold", 256'(lz0), 256'd20);

        // New digest arriving at byte 10 is ignored and flagged
        capture(ABC);
        stream(ABC, 0, 0, 10, 1'b0);
        chk("ovr_before", 256'(ovr0), 256'd0);
        hash = OTHER;
        rdy  = 1'b1;
        stream(ABC, 0, 10, 11, 1'b0);
        rdy  = 1'b0;
        stream(ABC, 0, 11, DIGEST_BYTES, 1'b0);
        chk("ovr_set", 256'(ovr0), 256'd1);
        chk("ovr_lz", 256'(lz0), 256'd0);

        // Asynchronous reset at byte 17, then restart from byte 0
        capture(ABC);
        stream(ABC, 0, 0, 17, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 256'(if0.valid_o), 256'd0);
        chk("mid_rst_busy", 256'(busy0), 256'd0);
        chk("mid_rst_byte", 256'(if0.byte_o), 256'd0);
        chk("mid_rst_lz", 256'(lz0), 256'd0);
        chk("mid_rst_ovr", 256'(ovr0), 256'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        capture(ABC);
        stream(ABC, 0, 0, DIGEST_BYTES, 1'b1);
        chk("post_rst_ovr", 256'(ovr0), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_digest_serializer.md
Name: sha256_digest_serializer

Overview:
Downstream stage of the SHA-256 core. It captures the 256-bit digest when the core's ready signal rises, then streams the digest out as 32 bytes over a valid/ready byte interface toward the board output path (UART/LED mux).
While capturing, it also registers the digest's leading-zero-bit count for the nonce/difficulty logic.

Parameters:
DIGEST_W, 256, digest width in bits; fixed at 256, exists for package consistency only.
MSB_FIRST, 1, 1 = first byte out is hash[255:248]; 0 = first byte out is hash[7:0].

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
rdy_i  input  1  core digest-ready level (core rdy_o).
hash_i  input  256  core digest (core hash_val), valid while rdy_i=1.
byte_o  output  8  current output byte.
valid_o  output  1  byte_o holds a valid byte.
ready_i  input  1  sink accepts byte_o on this edge.
busy_o  output  1  a digest is captured and not yet fully sent.
done_o  output  1  one-cycle pulse on the edge after the last byte is accepted.
lz_count_o  output  9  leading zero bits of the last captured digest (0..256).
overrun_o  output  1  sticky: a new digest arrived while busy.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; shift register=0; byte counter=0; rdy_prev=0; byte_o=0; valid_o=0; busy_o=0; done_o=0; lz_count_o=0; overrun_o=0.
- Reset mid-stream drops valid_o immediately and discards the remaining bytes.
- Edge detect: rise = rdy_i & ~rdy_prev; rdy_prev <= rdy_i every cycle. rdy_i=1 on the first edge after reset release counts as a rise.
- States: IDLE, SEND.
- IDLE:
  - On rise: shift_reg <= hash_i; cnt <= 0; lz_count_o <= lzc(hash_i); state -> SEND.
  - valid_o=1 and busy_o=1 from that edge (latency 1 clock from rdy_i high).
- SEND:
  - byte_o = shift_reg[255:248] (MSB_FIRST=1) or shift_reg[7:0] (MSB_FIRST=0).
  - Transfer happens when valid_o & ready_i at a rising edge.
  - On transfer with cnt<31: shift the register by 8 toward the output end; cnt++.
  - On transfer with cnt==31: state -> IDLE; valid_o=0; busy_o=0; done_o=1 for exactly one cycle.
  - While valid_o=1 and ready_i=0: byte_o and valid_o hold stable; no byte is dropped or duplicated.
  - A rise while in SEND: set overrun_o=1 (cleared only by reset); the new digest is ignored and the current stream continues unchanged.
- Rise on the same edge that the last byte transfers: the state is still SEND, so this counts as overrun and is not captured.
- Rise in IDLE during the done_o cycle: captured normally.
- lz_count_o:
  - Counts zeros from bit 255 downward; all-zero digest = 256.
  - Updated only at capture; holds until the next capture.
- cnt is 5 bits; it never wraps because SEND exits at 31.
- Max throughput: 1 byte/clock with ready_i tied high; 32 cycles per digest.

Decomposition:
- Package sha256_out_pkg: state enum (IDLE, SEND), DIGEST_BYTES=32, LZ_W=9.
- One sub-module, lzc256: combinational 256-bit leading-zero counter (9-bit result); instantiated once at the capture path.

Test Plan:
- "abc" digest ba7816bf...f20015ad, ready_i=1, MSB_FIRST=1 -> bytes ba,78,16,bf,...,15,ad on 32 consecutive cycles; done_o pulses once; lz_count_o=0.
- Same digest with ready_i toggling 1,0,0,1,... -> the identical 32-byte sequence; byte_o stable during each stall; no duplicates.
- hash_i=0 -> 32 bytes 00; lz_count_o=256. hash_i=0x00000fff...f -> lz_count_o=20.
- Second rdy_i rise at byte 10 with a different digest -> overrun_o=1; remaining 22 bytes still from the first digest.
- rst=0 at byte 17 -> valid_o=0 immediately, all outputs at reset values. Re-capture after release -> the stream restarts at byte 0.
- MSB_FIRST=0 with the "abc" digest -> first byte ad, last byte ba.
